buzzer_arbiter: RTL



---
 rtl/buzzer_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/buzzer_arbiter.sv
// Buzzer arbiter for the four GPIO-header player controllers.
// Synchronises and debounces each buzzer, picks the first rising press of an
// armed round, and holds that player's index and switch answer until acked.
module buzzer_arbiter #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] gpins,
    input  logic        enable,
    input  logic        ack,
    output logic        playerInputFlag,
    output logic [1:0]  firstPlayerFlag,
    output logic [7:0]  switchInput,
    output logic [1:0]  round_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ARMED  = 2'b01,
        LOCKED = 2'b10
    } round_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    round_t           state;
    round_t           state_next;
    logic [39:0]      sync_s1;
    logic [39:0]      sync_s2;
    logic [3:0]       buzz_s2;
    logic [3:0]       db;
    logic [3:0]       db_q;
    logic [3:0]       press;
    logic [CNT_W-1:0] cnt [4];
    logic [1:0]       winner;
    logic [7:0]       winner_sw;
    logic             capture;
    logic             clear_flag;
    logic             unused_pins;

    // Two-flop synchroniser on every header pin; everything downstream uses s2.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= gpins;
            sync_s2 <= sync_s1;
        end
    end

    // The spare pin of each controller is synchronised but has no consumer.
    assign unused_pins = ^{sync_s2[39], sync_s2[29], sync_s2[19], sync_s2[9]};

    // Pull the four synchronised buzzer bits out of the header layout.
    always_comb begin
        buzz_s2 = '0;
        for (int n = 0; n < 4; n++) begin
            buzz_s2[n] = sync_s2[10*n + 8];
        end
    end

    // Debounce: the level only follows s2 after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            db   <= '0;
            db_q <= '0;
            for (int n = 0; n < 4; n++) begin
                cnt[n] <= '0;
            end
        end else begin
            db_q <= db;
            for (int n = 0; n < 4; n++) begin
                if (buzz_s2[n] == db[n]) begin
                    cnt[n] <= '0;
                end else if (cnt[n] == CNT_LAST) begin
                    db[n]  <= buzz_s2[n];
                    cnt[n] <= '0;
                end else begin
                    cnt[n] <= cnt[n] + CNT_W'(1);
                end
            end
        end
    end

    // Rising edges of the debounced levels; lowest index wins a tie.
    always_comb begin
        press  = db & ~db_q;
        winner = 2'd0;
        for (int n = 3; n >= 0; n--) begin
            if (press[n]) begin
                winner = 2'(n);
            end
        end
        case (winner)
            2'd0:    winner_sw = sync_s2[7:0];
            2'd1:    winner_sw = sync_s2[17:10];
            2'd2:    winner_sw = sync_s2[27:20];
            default: winner_sw = sync_s2[37:30];
        endcase
    end

    // Round state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next round state; a dropped enable beats a same-cycle press.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (|press) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (ack) begin
                    state_next = enable ? ARMED : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Decode the capture and release strobes from the current state.
    always_comb begin
        capture     = (state == ARMED) && enable && (|press);
        clear_flag  = (state == LOCKED) && ack;
        round_state = state;
    end

    // Result registers: loaded on capture, flag dropped on ack, values held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            playerInputFlag <= 1'b0;
            firstPlayerFlag <= 2'd0;
            switchInput     <= 8'd0;
        end else if (capture) begin
            playerInputFlag <= 1'b1;
            firstPlayerFlag <= winner;
            switchInput     <= winner_sw;
        end else if (clear_flag) begin
            playerInputFlag <= 1'b0;
        end
    end

endmodule
